// File: rtl/power_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the power-state arbiter.
// The arbiter side is the slave modport; the requesters/observer side is the master.
interface power_grant_arbiter_if #(
  parameter int unsigned CNT_W = 4
);
  logic             req_0_i;
  logic             req_1_i;
  logic [2:0]       state_o;
  logic             busy_o;
  logic [CNT_W-1:0] hold_cnt_o;
  logic             last_grant_o;

  modport master (
    output req_0_i, req_1_i,
    input  state_o, busy_o, hold_cnt_o, last_grant_o
  );

  modport slave (
    input  req_0_i, req_1_i,
    output state_o, busy_o, hold_cnt_o, last_grant_o
  );
endinterface

// File: rtl/power_grant_arbiter.sv
// Two-requester round-robin arbiter emitting one-hot IDLE/GNT0/GNT1 power-state codes.
// Define POWER_GRANT_HOLD_TIMEOUT_EN to preempt a grant held MAX_HOLD cycles while the other side waits.
module power_grant_arbiter #(
  parameter int unsigned      CNT_W    = 4,
  parameter logic [CNT_W-1:0] MAX_HOLD = CNT_W'(12)
) (
  input  logic                       clock,
  input  logic                       reset,
  power_grant_arbiter_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    GNT0 = 3'b010,
    GNT1 = 3'b100
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_SAT = {CNT_W{1'b1}};

`ifdef POWER_GRANT_HOLD_TIMEOUT_EN
  localparam bit PREEMPT_EN = 1'b1;
`else
  localparam bit PREEMPT_EN = 1'b0;
`endif

  // Raw 3-bit register so that corrupted (non-one-hot) codes stay representable and recoverable.
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             timeout_c;

  assign timeout_c = PREEMPT_EN && (hold_q == MAX_HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    hold_d  = '0;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (bus.req_0_i && bus.req_1_i) state_d = last_q ? GNT0 : GNT1;
        else if (bus.req_0_i)           state_d = GNT0;
        else if (bus.req_1_i)           state_d = GNT1;
        else                            state_d = IDLE;
      end
      GNT0: begin
        if (bus.req_0_i)      state_d = (timeout_c && bus.req_1_i) ? GNT1 : GNT0;
        else if (bus.req_1_i) state_d = GNT1;
        else                  state_d = IDLE;
      end
      GNT1: begin
        if (bus.req_1_i)      state_d = (timeout_c && bus.req_0_i) ? GNT0 : GNT1;
        else if (bus.req_0_i) state_d = GNT0;
        else                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on any grant entry, counts while the same grant persists, saturates.
    if (state_d != IDLE && state_d == state_q) begin
      hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + CNT_W'(1);
    end

    if (state_d != state_q) begin
      if (state_d == GNT0)      last_d = 1'b0;
      else if (state_d == GNT1) last_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.state_o      = state_q;
  assign bus.busy_o       = busy_q;
  assign bus.hold_cnt_o   = hold_q;
  assign bus.last_grant_o = last_q;

endmodule

// File: doc/power_grant_arbiter.md
Name: power_grant_arbiter

Overview:
- Two-requester round-robin arbiter that produces the one-hot 3-bit power-state bus consumed by the grant-output decoder.
- Turns raw request lines req_0/req_1 into registered IDLE/GNT0/GNT1 state codes.
- Holds a grant until the owner releases it.
- Optionally preempts a long-held grant when the other requester is waiting.

Parameters:
- IDLE, 3'b001, state code for no grant
- GNT0, 3'b010, state code for grant to requester 0
- GNT1, 3'b100, state code for grant to requester 1
- CNT_W, 4, width of hold counter
- MAX_HOLD, 4'd12, hold cycles before preemption; used only with the optional feature; must be less than 2^CNT_W

Ports:
- clock, input, 1, rising-edge clock
- reset, input, 1, synchronous, active-high reset
- req_0, input, 1, request from requester 0; level-sensitive, held until done
- req_1, input, 1, request from requester 1
- state, output, 3, registered one-hot state code (IDLE/GNT0/GNT1)
- busy, output, 1, registered; 1 when state is GNT0 or GNT1
- hold_cnt, output, CNT_W, registered cycles in current grant
- last_grant, output, 1, registered round-robin pointer; 0 = requester 0 granted last

Behaviour:
- Reset (sampled on posedge clock while reset=1):
  - state=IDLE, busy=0, hold_cnt=0, last_grant=1, so requester 0 wins the first tie.
  - Reset overrides every other condition, including mid-grant.
- All outputs are registered. A request change affects state one cycle later, at the next posedge.
- IDLE:
  - req_0 only -> GNT0.
  - req_1 only -> GNT1.
  - both -> grant the requester opposite last_grant.
  - none -> stay IDLE.
- GNT0:
  - req_0=1 -> stay GNT0, unless the preemption condition holds.
  - req_0=0 and req_1=1 -> GNT1 directly, with no IDLE cycle.
  - req_0=0 and req_1=0 -> IDLE.
- GNT1: symmetric to GNT0.
- last_grant: updated on the same edge that enters a grant state (0 for GNT0, 1 for GNT1); otherwise held.
- hold_cnt:
  - Loads 0 on any edge that enters a grant state, including the direct GNT0<->GNT1 handoff.
  - Increments by 1 on each edge that stays in the same grant state.
  - Saturates at 2^CNT_W-1; it never wraps.
  - Forced to 0 in IDLE.
- busy equals (state != IDLE) and is registered together with state.
- Illegal state recovery: any state value other than the three codes (e.g. 3'b000, 3'b011, 3'b111) -> IDLE on the next edge, with hold_cnt=0.
- Simultaneous release by the owner and a new request from the same owner in one cycle cannot occur (level protocol). A one-cycle low on req_x is treated as a release.

Optional Feature:
- Macro: POWER_GRANT_HOLD_TIMEOUT_EN
- Defined:
  - While in GNTx with req_x=1, if the other requester is asserting and hold_cnt==MAX_HOLD, the next edge switches directly to the other grant state.
  - That switch updates last_grant and loads hold_cnt=0.
  - If the other requester is not asserting, there is no preemption. hold_cnt keeps counting and saturates.
- Undefined:
  - No preemption. A grant lasts until the owner releases it.
  - hold_cnt is still present and behaves identically (count, saturate).

Test Plan:
- Reset and first tie: reset=1 for 2 cycles, then req_0=req_1=1 -> state=001 at the first edge after reset, 010 at the next edge; last_grant=0, busy=1.
- Release and handoff: in GNT0 with req_1=1, drop req_0 -> state 010->100 in one edge with no 001 cycle; hold_cnt=0, last_grant=1.
- Round robin: both requests held from IDLE after a GNT1 grant -> GNT0 is chosen; release all -> 001; request both again -> 100.
- Saturation: hold req_0 only for 20 cycles -> hold_cnt reaches 15 and stays at 15; state stays 010.
- Preemption (macro defined): req_0 and req_1 held from cycle 0 with MAX_HOLD=12 -> GNT0 with hold_cnt 0..12, then state=100 on the next edge with hold_cnt=0. Macro undefined: state stays 010 indefinitely.
- Reset mid-grant and illegal state: assert reset while in GNT1 with hold_cnt=7 -> next edge state=001, hold_cnt=0, last_grant=1. Force the state register to 3'b011 -> next edge 001.
